// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory-port arbiter: FSM encoding and
// default timeout / starvation limits.
package mem_port_arbiter_pkg;

  localparam int unsigned TIMEOUT_DEF    = 255;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_counters.sv
// Starvation counter (data grants while a fetch waits) and busy-cycle counter
// for timeout detection; both are cleared/updated on grants from the arbiter FSM.
module arb_counters
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic fetch_waiting,
  input  logic busy,
  input  logic ack,
  output logic starve_full,
  output logic timeout_hit
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] BUSY_LIM   = 8'(TIMEOUT);

  logic [3:0] starve_cnt;
  logic [7:0] busy_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fetch_grant) begin
      starve_cnt <= '0;
    end else if (data_grant) begin
      if (!fetch_waiting)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Held at the limit so an aborting transaction never wraps the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= '0;
    end else if (data_grant || fetch_grant) begin
      busy_cnt <= '0;
    end else if (busy && !ack && busy_cnt != BUSY_LIM) begin
      busy_cnt <= busy_cnt + 8'd1;
    end
  end

  assign starve_full = (starve_cnt == STARVE_LIM);
  assign timeout_hit = busy && !ack && (busy_cnt == BUSY_LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one memory port; grant to memory
// request in one cycle, Ready one cycle after ack. Requesters stall while held.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IReqi,
  input  logic [DATA_W-1:0] IAddri,
  output logic [DATA_W-1:0] IRdatao,
  output logic              IReadyo,
  input  logic              DReqi,
  input  logic              DWei,
  input  logic [DATA_W-1:0] DAddri,
  input  logic [DATA_W-1:0] DWdatai,
  output logic [DATA_W-1:0] DRdatao,
  output logic              DReadyo,
  output logic              MemReqo,
  output logic              MemWeo,
  output logic [DATA_W-1:0] MemAddro,
  output logic [DATA_W-1:0] MemWdatao,
  input  logic [DATA_W-1:0] MemRdatai,
  input  logic              MemAcki,
  output logic              IStallo,
  output logic              DStallo,
  output logic              ErrTimeouto
);

  arb_state_e state, state_nxt;
  logic grant_i, grant_d;
  logic starve_full, timeout_hit;
  logic busy, done;

  assign busy = (state != ST_IDLE);
  assign done = busy && (MemAcki || timeout_hit);

  arb_counters #(
    .TIMEOUT    (TIMEOUT),
    .STARVE_MAX (STARVE_MAX)
  ) u_counters (
    .clk           (clk),
    .rst           (rst),
    .data_grant    (grant_d),
    .fetch_grant   (grant_i),
    .fetch_waiting (IReqi),
    .busy          (busy),
    .ack           (MemAcki),
    .starve_full   (starve_full),
    .timeout_hit   (timeout_hit)
  );

  // A Ready pulse blocks arbitration so the still-held request is not re-granted.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!(IReadyo || DReadyo)) begin
          if (DReqi && !(IReqi && starve_full)) begin
            grant_d   = 1'b1;
            state_nxt = ST_DBUSY;
          end else if (IReqi) begin
            grant_i   = 1'b1;
            state_nxt = ST_IBUSY;
          end
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (done)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MemReqo   <= 1'b0;
      MemWeo    <= 1'b0;
      MemAddro  <= '0;
      MemWdatao <= '0;
    end else begin
      MemReqo <= (state_nxt != ST_IDLE);
      if (grant_d) begin
        MemAddro  <= DAddri;
        MemWdatao <= DWdatai;
        MemWeo    <= DWei;
      end else if (grant_i) begin
        MemAddro  <= IAddri;
        MemWdatao <= '0;
        MemWeo    <= 1'b0;
      end else if (done) begin
        MemWeo    <= 1'b0;
      end
    end
  end

  // MemWeo still reflects the owning transaction's store flag while in DBUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IReadyo     <= 1'b0;
      DReadyo     <= 1'b0;
      IRdatao     <= '0;
      DRdatao     <= '0;
      ErrTimeouto <= 1'b0;
    end else begin
      IReadyo <= done && (state == ST_IBUSY);
      DReadyo <= done && (state == ST_DBUSY);
      if (state == ST_IBUSY && MemAcki)
        IRdatao <= MemRdatai;
      else if (state == ST_IBUSY && timeout_hit)
        IRdatao <= '0;
      if (state == ST_DBUSY && MemAcki && !MemWeo)
        DRdatao <= MemRdatai;
      else if (state == ST_DBUSY && timeout_hit)
        DRdatao <= '0;
      if (timeout_hit)
        ErrTimeouto <= 1'b1;
    end
  end

  assign IStallo = rst && IReqi && !IReadyo;
  assign DStallo = rst && DReqi && !DReadyo;

endmodule
